// File: rtl/main_memory_responder.sv
// main_memory_responder: word-addressed main-memory model below the L2 cache.
// Serves one read or write at a time. Each access completes LATENCY cycles after
// acceptance with a one-cycle mem_ready pulse. Words that were never written read
// back as (byte address + FILL_CONST).
// Optional feature macro: MEM_ADDR_CHECK_EN. When it is defined, misaligned or
// out-of-range addresses raise mem_error. An erroring write is dropped and an
// erroring read returns 32'hDEADDEAD.
module main_memory_responder #(
  parameter int          ADDR_BITS  = 10,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] FILL_CONST = 32'hA000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        mem_error
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [3:0]           r_cnt;
  logic                 r_write;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [31:0]          r_rdata;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_error;
  logic [DEPTH-1:0]     r_valid;
  logic [31:0]          r_mem [DEPTH];

  logic [ADDR_BITS-1:0] w_idx;
  logic                 w_err;
  logic                 w_finish;
  logic                 w_commit;
  logic [31:0]          w_read_val;

  // Upper address bits are dropped here, so aliasing addresses share a word.
  assign w_idx = r_addr[ADDR_BITS+1:2];

`ifdef MEM_ADDR_CHECK_EN
  assign w_err = (r_addr[1:0] != 2'b00) || (|(r_addr >> (ADDR_BITS + 2)));
`else
  assign w_err = 1'b0;
`endif

  // The edge that leaves WAIT with the counter at zero performs the access.
  assign w_finish   = (r_state == ST_WAIT) && (r_cnt == 4'd0);
  assign w_commit   = w_finish && r_write && !w_err;
  assign w_read_val = w_err          ? 32'hDEAD_DEAD :
                      r_valid[w_idx] ? r_mem[w_idx]  :
                                       (r_addr + FILL_CONST);

  // Request FSM: captures the request, counts latency, completes the access.
  // Reset aborts any in-flight access and clears every written-valid bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_error <= 1'b0;
      r_valid <= '0;
    end else begin
      r_ready <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (mem_req) begin
            r_write <= mem_write;
            r_addr  <= mem_addr;
            r_wdata <= mem_write_data;
            r_cnt   <= 4'(LATENCY - 1);
            r_busy  <= 1'b1;
            r_state <= ST_WAIT;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_DONE;
            r_ready <= 1'b1;
            r_error <= w_err;
            if (r_write) begin
              if (!w_err) begin
                r_valid[w_idx] <= 1'b1;
              end else begin
                r_valid <= r_valid;
              end
            end else begin
              r_rdata <= w_read_val;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: deliberately not reset, and written only by a completing write.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  assign mem_read_data = r_rdata;
  assign mem_ready     = r_ready;
  assign mem_busy      = r_busy;
  assign mem_error     = r_error;

endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench for main_memory_responder.
// Stimulus pushes the expected completion into a queue. The expected completion
// holds the cycle, mem_read_data and mem_error. A monitor pops an entry and
// compares it against the DUT on every mem_ready pulse.
module tb_main_memory_responder;

  localparam int LAT_D = 2;
  localparam int LAT_E = 1;

  typedef struct {
    int          t;
    logic [31:0] rd;
    logic        err;
    string       nm;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int          cyc;
  int          n_tests;
  int          n_fail;
  exp_t        qd[$];
  exp_t        qe[$];

  logic        d_req, d_wr;
  logic [31:0] d_addr, d_wd, d_rd;
  logic        d_ready, d_busy, d_error;

  logic        e_req, e_wr;
  logic [31:0] e_addr, e_wd, e_rd;
  logic        e_ready, e_busy, e_error;

  main_memory_responder #(.ADDR_BITS(10), .LATENCY(LAT_D), .FILL_CONST(32'hA000_0000)) dut (
    .clk(clk), .reset(rst_n), .mem_req(d_req), .mem_write(d_wr), .mem_addr(d_addr),
    .mem_write_data(d_wd), .mem_read_data(d_rd), .mem_ready(d_ready),
    .mem_busy(d_busy), .mem_error(d_error)
  );

  main_memory_responder #(.ADDR_BITS(10), .LATENCY(LAT_E), .FILL_CONST(32'hA000_0000)) dut_l1 (
    .clk(clk), .reset(rst_n), .mem_req(e_req), .mem_write(e_wr), .mem_addr(e_addr),
    .mem_write_data(e_wd), .mem_read_data(e_rd), .mem_ready(e_ready),
    .mem_busy(e_busy), .mem_error(e_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter stamped by each rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor for the LATENCY=2 instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (d_ready) begin
        if (qd.size() == 0) begin
          check("d_unexpected_ready", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = qd.pop_front();
          check({e.nm, "_cycle"}, 32'(cyc), 32'(e.t));
          check({e.nm, "_rdata"}, d_rd, e.rd);
          check({e.nm, "_error"}, 32'(d_error), 32'(e.err));
          check({e.nm, "_busy_in_done"}, 32'(d_busy), 32'd1);
        end
      end else if (d_error) begin
        check("d_stray_error", 32'(d_error), 32'd0);
      end
    end
  end

  // Monitor for the LATENCY=1 instance.
  always @(negedge clk) begin
    if (rst_n && e_ready) begin
      if (qe.size() == 0) begin
        check("e_unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qe.pop_front();
        check({e.nm, "_cycle"}, 32'(cyc), 32'(e.t));
        check({e.nm, "_rdata"}, e_rd, e.rd);
        check({e.nm, "_error"}, 32'(e_error), 32'(e.err));
      end
    end
  end

  // Bounded wait until the LATENCY=2 instance reports idle; called at a negedge.
  task automatic wait_idle();
    for (int i = 0; i < 20 && d_busy; i++) @(negedge clk);
    if (d_busy) check("wait_idle_timeout", 32'(d_busy), 32'd0);
  endtask

  // Issue one access at a negedge while idle. Corrupt the inputs right after
  // acceptance so that the test also proves the request fields were captured.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input string nm);
    exp_t e;
    d_req = 1'b1; d_wr = wr; d_addr = addr; d_wd = wd;
    e.t = cyc + 1 + LAT_D; e.rd = exp_rd; e.err = exp_err; e.nm = nm;
    qd.push_back(e);
    @(posedge clk); #1;
    check({nm, "_busy_rise"}, 32'(d_busy), 32'd1);
    d_req = 1'b0; d_wr = ~wr; d_addr = 32'hFFFF_FFFC; d_wd = 32'h0BAD_0BAD;
    wait_idle();
  endtask

  initial begin
    exp_t e;
    int c;
    n_tests = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0;
    d_req = 1'b0; d_wr = 1'b0; d_addr = 32'd0; d_wd = 32'd0;
    e_req = 1'b0; e_wr = 1'b0; e_addr = 32'd0; e_wd = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_rdata", d_rd, 32'd0);
    check("rst_ready", 32'(d_ready), 32'd0);
    check("rst_busy",  32'(d_busy),  32'd0);
    check("rst_error", 32'(d_error), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Untouched word returns the fill pattern.
    issue(1'b0, 32'h0000_0400, 32'd0, 32'hA000_0400, 1'b0, "rd_fill_400");
    // Write keeps the previous read data; read-after-write returns the written word.
    issue(1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 32'hA000_0400, 1'b0, "wr_0");
    issue(1'b0, 32'h0000_0000, 32'd0, 32'hDEAD_BEEF, 1'b0, "rd_0");

    // Request held for 6 edges: accepted at c+1 and again at c+5 only.
    c = cyc;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h0000_0100;
    e.t = c + 1 + LAT_D; e.rd = 32'hA000_0100; e.err = 1'b0; e.nm = "held_a"; qd.push_back(e);
    e.t = c + 5 + LAT_D; e.nm = "held_b"; qd.push_back(e);
    repeat (6) @(negedge clk);
    d_req = 1'b0;
    wait_idle();

    // Reset mid-WAIT aborts a write and clears the valid bits.
    issue(1'b1, 32'h0000_0200, 32'hCAFE_F00D, 32'hA000_0100, 1'b0, "wr_200");
    d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h0000_0200; d_wd = 32'h1234_5678;
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    check("abort_in_wait_busy", 32'(d_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rdata", d_rd, 32'd0);
    check("mid_rst_busy",  32'(d_busy),  32'd0);
    check("mid_rst_ready", 32'(d_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 32'h0000_0200, 32'd0, 32'hA000_0200, 1'b0, "rd_200_after_rst");

`ifdef MEM_ADDR_CHECK_EN
    issue(1'b0, 32'h0000_0002, 32'd0, 32'hDEAD_DEAD, 1'b1, "rd_misaligned");
    issue(1'b1, 32'h0000_1000, 32'h5555_5555, 32'hDEAD_DEAD, 1'b1, "wr_out_of_range");
    issue(1'b0, 32'h0000_0000, 32'd0, 32'hA000_0000, 1'b0, "rd_0_unaffected");
`else
    // Upper bits alias and the low two bits are ignored.
    issue(1'b1, 32'h0000_1004, 32'h1111_2222, 32'hA000_0200, 1'b0, "wr_alias_1004");
    issue(1'b0, 32'h0000_0004, 32'd0, 32'h1111_2222, 1'b0, "rd_alias_4");
    issue(1'b0, 32'h0000_0006, 32'd0, 32'h1111_2222, 1'b0, "rd_unaligned_6");
    issue(1'b0, 32'h0000_1010, 32'd0, 32'hA000_1010, 1'b0, "rd_fill_1010");
`endif

    // LATENCY=1: ready one cycle after acceptance; a held request is re-accepted
    // right after the DONE cycle (accepted at c+1 and again at c+4).
    @(negedge clk);
    c = cyc;
    e_req = 1'b1; e_wr = 1'b0; e_addr = 32'h0000_000C;
    e.t = c + 1 + LAT_E; e.rd = 32'hA000_000C; e.err = 1'b0; e.nm = "l1_a"; qe.push_back(e);
    e.t = c + 4 + LAT_E; e.nm = "l1_b"; qe.push_back(e);
    repeat (4) @(negedge clk);
    e_req = 1'b0;
    repeat (5) @(negedge clk);

    check("qd_drained", 32'(qd.size()), 32'd0);
    check("qe_drained", 32'(qe.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
